// File: rtl/usr_btn_debounce.sv
// usr_btn_debounce: board user-button conditioner.
// Synchronizes the raw pad into clk48 and debounces it into a stable level.
// Also produces one-cycle press/release/long-press strobes, a wrapping press
// counter, and a one-deep event register with a sticky overflow flag.
module usr_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       usr_btn,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf,
  input  logic       clr_ovf
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // The pad level that means "not pressed"; the synchronizer starts here so
  // that reset exit never looks like an edge.
  localparam logic PAD_RELEASED = BTN_ACTIVE_LOW;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_LONG    = 2'b11;

  // Registered state
  logic [1:0]        sync_q,        sync_d;
  logic              stable_q,      stable_d;
  logic [DB_W-1:0]   db_cnt_q,      db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic              press_q,       press_d;
  logic              release_q,     release_d;
  logic              long_q,        long_d;
  logic [7:0]        press_count_q, press_count_d;
  logic              evt_valid_q,   evt_valid_d;
  logic [1:0]        evt_code_q,    evt_code_d;
  logic              evt_ovf_q,     evt_ovf_d;

  // Combinational helpers
  logic       pressed_sync;
  logic       new_evt;
  logic [1:0] new_code;

  // Two-stage synchronizer: stage 0 samples the pad, stage 1 feeds the debouncer.
  always_comb begin
    sync_d       = {sync_q[0], usr_btn};
    pressed_sync = sync_q[1] ^ BTN_ACTIVE_LOW;
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d  = stable_q;
    db_cnt_d  = db_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (pressed_sync == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d  = ~stable_q;
      db_cnt_d  = '0;
      press_d   = ~stable_q;
      release_d = stable_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  // Long-press timer: counts held cycles and saturates, so it fires once per press.
  // A release on the very edge the timer would expire wins, so release and
  // long never compete for the event register.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    if (!stable_q || release_d) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q < HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HOLD_ONE;
      long_d     = (hold_cnt_q == HOLD_LAST);
    end
  end

  // Press counter: wraps naturally at 8 bits.
  always_comb begin
    press_count_d = press_count_q + {7'd0, press_d};
  end

  // Event slot: load when empty or being drained, otherwise drop and flag overflow.
  always_comb begin
    new_evt     = press_d | release_d | long_d;
    new_code    = EVT_NONE;
    if (press_d) begin
      new_code = EVT_PRESS;
    end else if (release_d) begin
      new_code = EVT_RELEASE;
    end else if (long_d) begin
      new_code = EVT_LONG;
    end

    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ovf_d   = evt_ovf_q;

    if (new_evt && (!evt_valid_q || evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_code_d  = new_code;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
      evt_code_d  = EVT_NONE;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (new_evt && evt_valid_q && !evt_ready) begin
      evt_ovf_d = 1'b1;
    end else if (clr_ovf) begin
      evt_ovf_d = 1'b0;
    end
  end

  // All state flops; reset puts everything into the released, empty state.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= {2{PAD_RELEASED}};
      stable_q      <= 1'b0;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_q        <= 1'b0;
      press_count_q <= '0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= EVT_NONE;
      evt_ovf_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      press_q       <= press_d;
      release_q     <= release_d;
      long_q        <= long_d;
      press_count_q <= press_count_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_ovf_q     <= evt_ovf_d;
    end
  end

  assign btn_level     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = press_count_q;
  assign evt_valid     = evt_valid_q;
  assign evt_code      = evt_code_q;
  assign evt_ovf       = evt_ovf_q;

endmodule

// File: tb/tb_usr_btn_debounce.sv
// Directed bench for usr_btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Inputs change and outputs are sampled on the falling edge of clk48.
module tb_usr_btn_debounce;

  logic       clk48;
  logic       rst_n;
  logic       usr_btn;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_ovf;
  logic       clr_ovf;

  int n_checks = 0;
  int n_err    = 0;
  int n_press  = 0;
  int n_rel    = 0;
  int n_long   = 0;
  int n_valid  = 0;

  usr_btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .usr_btn      (usr_btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .evt_ovf      (evt_ovf),
    .clr_ovf      (clr_ovf)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance n falling edges, tallying strobes seen along the way.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk48);
      if (press_pulse)   n_press++;
      if (release_pulse) n_rel++;
      if (long_pulse)    n_long++;
      if (evt_valid)     n_valid++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    usr_btn   = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    // Reset state
    step(3);
    chk("rst_level", btn_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code",  evt_code, 0);
    chk("rst_count", press_count, 0);
    chk("rst_ovf",   evt_ovf, 0);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_level", btn_level, 0);
    chk("post_rst_valid", evt_valid, 0);

    // Clean press: everything rises at edge 5
    usr_btn = 1'b0;
    n_press = 0;
    step(5);
    chk("press_e4_level", btn_level, 0);
    step(1);
    chk("press_e5_level", btn_level, 1);
    chk("press_e5_pulse", press_pulse, 1);
    chk("press_e5_valid", evt_valid, 1);
    chk("press_e5_code",  evt_code, 1);
    chk("press_e5_count", press_count, 1);
    step(1);
    chk("press_e6_pulse", press_pulse, 0);
    chk("press_npulse",   n_press, 1);
    evt_ready = 1'b1;
    step(1);
    chk("consume_valid", evt_valid, 0);
    chk("consume_code",  evt_code, 0);

    // Long press: btn_level rose at edge 5, long expected at edge 21
    n_long = 0;
    step(13);
    chk("long_e20", long_pulse, 0);
    step(1);
    chk("long_e21",       long_pulse, 1);
    chk("long_e21_valid", evt_valid, 1);
    chk("long_e21_code",  evt_code, 3);
    step(15);
    chk("long_once",   n_long, 1);
    chk("long_after",  long_pulse, 0);
    chk("long_drained", evt_valid, 0);

    // Release after long press
    usr_btn = 1'b1;
    n_rel = 0;
    step(5);
    chk("rel_e4_level", btn_level, 1);
    step(1);
    chk("rel_e5_level", btn_level, 0);
    chk("rel_e5_pulse", release_pulse, 1);
    chk("rel_e5_valid", evt_valid, 1);
    chk("rel_e5_code",  evt_code, 2);
    step(1);
    chk("rel_drained", evt_valid, 0);
    chk("rel_npulse",  n_rel, 1);

    // Bounce: 3-cycle lows with 1-cycle high gaps never get accepted
    n_press = 0;
    n_valid = 0;
    for (int k = 0; k < 5; k++) begin
      usr_btn = 1'b0;
      step(3);
      usr_btn = 1'b1;
      step(1);
    end
    step(8);
    chk("bounce_npress", n_press, 0);
    chk("bounce_nvalid", n_valid, 0);
    chk("bounce_level",  btn_level, 0);
    chk("bounce_count",  press_count, 1);

    // Overflow: held press event, later events dropped
    evt_ready = 1'b0;
    usr_btn = 1'b0;
    step(6);
    chk("ovf_p1_valid", evt_valid, 1);
    chk("ovf_p1_code",  evt_code, 1);
    chk("ovf_p1_flag",  evt_ovf, 0);
    usr_btn = 1'b1;
    step(6);
    chk("ovf_r1_flag", evt_ovf, 1);
    chk("ovf_r1_code", evt_code, 1);
    usr_btn = 1'b0;
    step(6);
    chk("ovf_p2_code",  evt_code, 1);
    chk("ovf_p2_count", press_count, 3);
    usr_btn = 1'b1;
    step(5);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf_setwins_level", btn_level, 0);
    chk("ovf_setwins_flag",  evt_ovf, 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf_clr_flag", evt_ovf, 0);
    chk("ovf_held_valid", evt_valid, 1);
    chk("ovf_held_code",  evt_code, 1);
    evt_ready = 1'b1;
    step(1);
    chk("ovf_drain_valid", evt_valid, 0);

    // Wrap: 256 presses from reset with a ready consumer
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    n_press = 0;
    for (int k = 0; k < 256; k++) begin
      usr_btn = 1'b0;
      step(6);
      usr_btn = 1'b1;
      step(6);
      if (k == 254) chk("wrap_count255", press_count, 255);
    end
    chk("wrap_count0", press_count, 0);
    chk("wrap_npress", n_press, 256);
    chk("wrap_ovf",    evt_ovf, 0);

    // Reset mid-debounce with pending event and overflow
    evt_ready = 1'b0;
    usr_btn = 1'b0;
    step(6);
    usr_btn = 1'b1;
    step(6);
    chk("mid_pre_ovf",   evt_ovf, 1);
    chk("mid_pre_count", press_count, 1);
    chk("mid_pre_valid", evt_valid, 1);
    usr_btn = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_code",  evt_code, 0);
    chk("mid_rst_ovf",   evt_ovf, 0);
    chk("mid_rst_count", press_count, 0);
    chk("mid_rst_pulse", press_pulse, 0);
    step(2);
    rst_n = 1'b1;
    n_press = 0;
    step(5);
    chk("mid_exit_e4_pulse", press_pulse, 0);
    chk("mid_exit_e4_level", btn_level, 0);
    step(1);
    chk("mid_exit_e5_pulse", press_pulse, 1);
    chk("mid_exit_e5_count", press_count, 1);
    chk("mid_exit_npress",   n_press, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/usr_btn_debounce.md
# usr_btn_debounce

Input-side conditioner for the board user button. It takes the raw asynchronous `usr_btn` pad and delivers clean, debounced state to the LED and control logic in the `clk48` domain. It provides a stable level, single-cycle press/release/long-press pulses, a wrapping press counter, and a one-deep valid/ready event register with a sticky overflow flag. It sits between the `usr_btn` pad and any consumer that currently samples the raw pin.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 480000 (10 ms at 48 MHz): consecutive differing samples required to accept a new level; must be ≥ 1.
- `LONG_CYCLES`, 48000000 (1 s): cycles of held press before the long-press event; must be ≥ 1.
- `BTN_ACTIVE_LOW`, 1: 1 means pad low = pressed.

Ports:
- `clk48`  in  1  system clock, 48 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `usr_btn`  in  1  raw button pad, asynchronous to `clk48`.
- `btn_level`  out  1  debounced state, 1 = pressed.
- `press_pulse`  out  1  one-cycle strobe on accepted press.
- `release_pulse`  out  1  one-cycle strobe on accepted release.
- `long_pulse`  out  1  one-cycle strobe when a press has been held `LONG_CYCLES`.
- `press_count`  out  8  count of accepted presses; wraps at 255.
- `evt_valid`  out  1  event register holds an unconsumed event.
- `evt_code`  out  2  event type: 01 press, 10 release, 11 long; 00 when empty.
- `evt_ready`  in  1  consumer accepts the event on a cycle where `evt_valid` is 1.
- `evt_ovf`  out  1  sticky: at least one event was dropped.
- `clr_ovf`  in  1  clears `evt_ovf`.

## Operation
- Synchronizer:
  - Two flops on `usr_btn`, reset to the released pad level.
  - `pressed_sync` = sync2 XOR `BTN_ACTIVE_LOW`.
- Debounce:
  - State register `stable` drives `btn_level`.
  - Counter `db_cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - When `pressed_sync == stable`: `db_cnt` ← 0.
  - Otherwise, if `db_cnt == DEBOUNCE_CYCLES-1`: `stable` toggles and `db_cnt` ← 0.
  - Otherwise: `db_cnt` increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples restarts the count and never changes `stable`.
- Pulses: registered on the same edge that toggles `stable`.
  - 0→1 toggle: `press_pulse`, and `press_count` increments.
  - 1→0 toggle: `release_pulse`.
- Long press:
  - `hold_cnt` is `$clog2(LONG_CYCLES+1)` bits.
  - Cleared while `stable` is 0 and on the press edge.
  - While `stable` is 1 and `hold_cnt < LONG_CYCLES`, it increments.
  - `long_pulse` fires on the edge where `hold_cnt` goes from `LONG_CYCLES-1` to `LONG_CYCLES`, then saturates. At most one `long_pulse` per press.
  - Release before saturation produces no long event.
- Event register, a one-deep skid slot:
  - An accepted event is loaded (`evt_valid` ← 1, `evt_code` ← type) when the register is empty, or is being consumed this cycle (`evt_valid && evt_ready`).
  - A consume with no new event sets `evt_valid` ← 0 and `evt_code` ← 00.
  - An event arriving while `evt_valid && !evt_ready` is dropped and sets `evt_ovf`. The held event is unchanged.
  - `clr_ovf` clears `evt_ovf`. If a drop and `clr_ovf` occur in the same cycle, set wins.
  - `evt_code` is stable while `evt_valid && !evt_ready`.
- Press and long events cannot coincide, because `LONG_CYCLES` ≥ 1.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `btn_level`, all pulses, `press_count`, `evt_valid`, `evt_ovf`: 0.
  - `evt_code`: 00.
  - `db_cnt` and `hold_cnt`: 0.
  - Synchronizer: released level.
- Deassertion of `rst_n` is glitch-free with respect to the outputs. No event is generated on reset exit, even if the button is held: a held button is accepted after the normal debounce latency as a fresh press.
- Latency: `usr_btn` changes and holds before edge 0. Then:
  - `btn_level`, the corresponding pulse, and `evt_valid` update on edge `DEBOUNCE_CYCLES+1`, visible from that edge.
  - `long_pulse` is asserted exactly `LONG_CYCLES` cycles after `btn_level` rises.
- Pulses are high for exactly one `clk48` cycle.
- Reset mid-debounce or mid-hold discards the partial count, any pending event, and the overflow flag.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=16`, `BTN_ACTIVE_LOW=1` unless noted.
- Clean press: drive `usr_btn` 1→0 before edge 0 and hold → `btn_level`, `press_pulse`, `evt_valid` with `evt_code`=01 all rise at edge 5; `press_count`=1.
- Bounce: pulse `usr_btn` low for 3 cycles, 5 times with 1-cycle high gaps → `btn_level` stays 0, no pulses, no events.
- Long press: hold low 30 cycles with `evt_ready`=1 → `long_pulse` 16 cycles after `btn_level` rise, `evt_code`=11 once. Release → `release_pulse` and `evt_code`=10 at the release edge + 5.
- Overflow: `evt_ready`=0; press, release, press (all debounced) → `evt_code` stays 01 and `evt_ovf`=1. Assert `clr_ovf` in the same cycle as another drop → `evt_ovf` stays 1; assert `clr_ovf` alone → 0.
- Wrap: 256 debounced presses → `press_count` reads 0; `evt_ready`=1 on every event gives no overflow.
- Reset mid-operation: assert `rst_n`=0 at `db_cnt`=2 with the button held low → all outputs 0 immediately. After release of reset with the button still held, `press_pulse` appears at edge 5.
